vt52_video_colorizer: RTL and testbench
=======================================

Name: vt52_video_colorizer

Overview:
- Output stage between the VT52 terminal video generator and the VGA/HDMI output signals.
- Expands an IN_W-bit monochrome level to 8-bit RGB using a selectable phosphor tint and optional inversion, and keeps sync and blank aligned with the colour pipeline.
- Adds a frame-counted visual-bell flash and a breathing activity LED.
- Replaces the fixed 1-bit-to-white replication.

Parameters:
- IN_W, 1, width of the input video level (1..8).
- FLASH_FRAMES, 4, number of frames the screen stays inverted per flash request (1..255).
- LED_CNT_W, 27, width of the LED breathing counter (minimum 10).

Ports:
- clk  in  1  pixel/system clock.
- reset_n  in  1  asynchronous active-low reset.
- ce_pix  in  1  pixel enable; all video pipeline stages advance only when this is 1.
- video_in  in  IN_W  monochrome intensity.
- hsync_in  in  1  horizontal sync.
- vsync_in  in  1  vertical sync, active high.
- hblank_in  in  1  horizontal blank.
- vblank_in  in  1  vertical blank.
- tint  in  3  colour select: 0 white, 1 red, 2 green, 3 blue, 4 amber, 5-7 white.
- invert  in  1  invert the level (dark text on bright background).
- flash_req  in  1  one-clock pulse requesting a visual-bell flash.
- vga_r  out  8  red output.
- vga_g  out  8  green output.
- vga_b  out  8  blue output.
- vga_hs  out  1  delayed horizontal sync.
- vga_vs  out  1  delayed vertical sync.
- vga_de  out  1  delayed data enable.
- flash_busy  out  1  high while a flash is pending or active.
- frame_cnt  out  8  count of vsync rising edges.
- led  out  1  breathing activity LED.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All outputs 0.
  - frame_cnt 0; flash counter 0; flash_busy 0.
  - Active tint = white; active invert = 0; LED counter 0.
  - All pipeline registers 0.
- Level expansion (stage 1):
  - L8 is video_in replicated MSB-first until 8 bits are filled.
  - IN_W=1 gives 0x00 or 0xFF.
  - IN_W=3 with value 3'b101 gives 8'b10110110.
- Vsync edge detection:
  - vs_rise is sampled on ce_pix.
  - vs_rise = vsync_in=1 while the previous ce-sampled vsync_in=0.
- Frame-boundary shadowing:
  - tint and invert are copied to the active registers only on vs_rise.
  - Changes mid-frame take effect at the next frame, never mid-line.
- Frame counter:
  - frame_cnt increments on each vs_rise.
  - Wraps 255 -> 0.
- Flash:
  - flash_req sets a pending flag and flash_busy=1 on the next clock, independent of ce_pix.
  - On the next vs_rise with pending set: flash counter loads FLASH_FRAMES and pending clears.
  - The counter decrements on each subsequent vs_rise; the flash is active while the counter is nonzero.
  - flash_busy = pending OR counter != 0.
  - flash_req while active sets pending again, so the flash restarts at the next vs_rise (counter reloads, no gap).
  - flash_req coincident with vs_rise: the reload happens on that same edge.
- Effective inversion = active invert XOR flash active; applied to L8 as a bitwise NOT.
- Colour map (stage 2), from level L:
  - White: R=G=B=L.
  - Red: R=L, G=B=0.
  - Green: G=L, others 0.
  - Blue: B=L, others 0.
  - Amber: R=L, G=L-(L>>2) truncated to 8 bits, B=0 (L=0xFF gives G=0xC0).
- Pipeline and alignment:
  - Latency is exactly 2 ce_pix-qualified cycles.
  - hsync_in, vsync_in and de_in = ~(hblank_in|vblank_in) pass through a matching 2-stage delay.
  - When the delayed DE=0, vga_r/g/b are forced to 0.
  - With ce_pix held 0, all outputs hold their values.
- LED:
  - Free-running LED_CNT_W counter, not gated by ce_pix.
  - Let c = counter, W = LED_CNT_W, D = c[W-2:W-9], P = c[7:0].
  - If c[W-1]=1: led = (D > P). Otherwise: led = (D <= P).
  - Forced to 1 while flash_busy.
- Reset asserted mid-frame: outputs drop to 0 asynchronously. After release, the first frame uses white with no invert until the first vs_rise.

Test Plan:
- Reset release, IN_W=1, ce_pix=1, tint=0, video_in=1 with blanks low -> from the 2nd cycle after input, vga_r/g/b=0xFF and vga_de=1; vga_hs/vga_vs track their inputs with 2-cycle delay.
- IN_W=3, video_in=3'b101, tint=4 applied via one vsync pulse -> R=0xB6, G=0x89, B=0x00.
- Change tint 0->2 mid-frame -> output remains white until the next vsync rising edge, then G=0xFF and R=B=0x00.
- FLASH_FRAMES=4, flash_req pulse mid-frame -> flash_busy=1 the next clock; inverted output for exactly 4 frames from the next vs_rise; flash_busy=0 after the 5th vs_rise. A second request in frame 2 -> inversion extends to 4 frames from the restart.
- hblank_in=1 with video_in=1 -> vga_r/g/b=0 and vga_de=0, delayed by 2 cycles. ce_pix held 0 for 10 cycles -> all outputs frozen.
- 256 vsync pulses -> frame_cnt wraps to 0. Assert reset_n=0 mid-line -> all outputs read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vt52_video_colorizer.sv
// VT52 video output stage: monochrome level -> tinted 8-bit RGB with a 2-stage
// ce_pix pipeline, frame-aligned tint/invert shadowing, visual-bell flash and a breathing LED.
module vt52_video_colorizer #(
  parameter int IN_W         = 1,
  parameter int FLASH_FRAMES = 4,
  parameter int LED_CNT_W    = 27
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ce_pix,
  input  logic [IN_W-1:0] video_in,
  input  logic            hsync_in,
  input  logic            vsync_in,
  input  logic            hblank_in,
  input  logic            vblank_in,
  input  logic [2:0]      tint,
  input  logic            invert,
  input  logic            flash_req,
  output logic [7:0]      vga_r,
  output logic [7:0]      vga_g,
  output logic [7:0]      vga_b,
  output logic            vga_hs,
  output logic            vga_vs,
  output logic            vga_de,
  output logic            flash_busy,
  output logic [7:0]      frame_cnt,
  output logic            led
);

  localparam logic [2:0] TINT_WHITE = 3'd0;
  localparam logic [2:0] TINT_RED   = 3'd1;
  localparam logic [2:0] TINT_GREEN = 3'd2;
  localparam logic [2:0] TINT_BLUE  = 3'd3;
  localparam logic [2:0] TINT_AMBER = 3'd4;
  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);

  logic                 vs_prev;
  logic                 vs_rise;
  logic [2:0]           tint_act;
  logic                 inv_act;
  logic                 flash_pend;
  logic [7:0]           flash_cnt;
  logic                 flash_active;
  logic                 inv_eff;
  logic [7:0]           l8;
  logic [7:0]           lvl1;
  logic                 hs1;
  logic                 vs1;
  logic                 de1;
  logic                 de_in;
  logic [7:0]           amber_g;
  logic [7:0]           r_nx;
  logic [7:0]           g_nx;
  logic [7:0]           b_nx;
  logic [LED_CNT_W-1:0] led_cnt;
  logic [7:0]           led_d;
  logic [7:0]           led_p;
  logic                 breathe;

  // Edge detection runs on the pixel-enable so sync is seen at pixel rate only.
  assign vs_rise      = ce_pix & vsync_in & ~vs_prev;
  assign flash_active = (flash_cnt != 8'd0);
  assign inv_eff      = inv_act ^ flash_active;
  assign flash_busy   = flash_pend | flash_active;
  assign de_in        = ~(hblank_in | vblank_in);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev   <= 1'b0;
      tint_act  <= TINT_WHITE;
      inv_act   <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      if (ce_pix) begin
        vs_prev <= vsync_in;
      end
      if (vs_rise) begin
        tint_act  <= tint;
        inv_act   <= invert;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // A request landing on the same edge as vs_rise reloads immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flash_pend <= 1'b0;
      flash_cnt  <= 8'd0;
    end else if (vs_rise && (flash_pend || flash_req)) begin
      flash_cnt  <= FLASH_LOAD;
      flash_pend <= 1'b0;
    end else begin
      if (vs_rise && flash_active) begin
        flash_cnt <= flash_cnt - 8'd1;
      end
      if (flash_req) begin
        flash_pend <= 1'b1;
      end
    end
  end

  // MSB-first replication of the input level into 8 bits.
  always_comb begin
    l8 = 8'd0;
    for (int i = 0; i < 8; i++) begin
      l8[7-i] = video_in[IN_W-1-(i%IN_W)];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lvl1 <= 8'd0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
      de1  <= 1'b0;
    end else if (ce_pix) begin
      lvl1 <= l8 ^ {8{inv_eff}};
      hs1  <= hsync_in;
      vs1  <= vsync_in;
      de1  <= de_in;
    end
  end

  assign amber_g = lvl1 - {2'b00, lvl1[7:2]};

  always_comb begin
    r_nx = 8'd0;
    g_nx = 8'd0;
    b_nx = 8'd0;
    if (de1) begin
      case (tint_act)
        TINT_RED:   r_nx = lvl1;
        TINT_GREEN: g_nx = lvl1;
        TINT_BLUE:  b_nx = lvl1;
        TINT_AMBER: begin
          r_nx = lvl1;
          g_nx = amber_g;
        end
        default: begin
          r_nx = lvl1;
          g_nx = lvl1;
          b_nx = lvl1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_r  <= 8'd0;
      vga_g  <= 8'd0;
      vga_b  <= 8'd0;
      vga_hs <= 1'b0;
      vga_vs <= 1'b0;
      vga_de <= 1'b0;
    end else if (ce_pix) begin
      vga_r  <= r_nx;
      vga_g  <= g_nx;
      vga_b  <= b_nx;
      vga_hs <= hs1;
      vga_vs <= vs1;
      vga_de <= de1;
    end
  end

  // Breathing: the duty ramp D is compared to a fast PWM phase P; the top bit
  // flips the comparison so brightness rises then falls.
  assign led_d   = led_cnt[LED_CNT_W-2 -: 8];
  assign led_p   = led_cnt[7:0];
  assign breathe = led_cnt[LED_CNT_W-1] ? (led_d > led_p) : (led_d <= led_p);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_cnt <= '0;
      led     <= 1'b0;
    end else begin
      led_cnt <= led_cnt + 1'b1;
      led     <= flash_busy | breathe;
    end
  end

endmodule

// File: tb/tb_vt52_video_colorizer.sv
// Directed bench for vt52_video_colorizer: two instances (1-bit and 3-bit video)
// share all control inputs; a reference model feeds an expected-output queue.
module tb_vt52_video_colorizer;

  localparam int FF_N  = 4;
  localparam int LED_W = 10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce_pix;
  logic [0:0] video1;
  logic [2:0] video3;
  logic       hsync, vsync, hblank, vblank;
  logic [2:0] tint;
  logic       invert;
  logic       flash_req;

  logic [7:0] r1, g1, b1, fc1;
  logic       hs1, vs1, de1, busy1, led1;
  logic [7:0] r3, g3, b3, fc3;
  logic       hs3, vs3, de3, busy3, led3;

  vt52_video_colorizer #(.IN_W(1), .FLASH_FRAMES(FF_N), .LED_CNT_W(LED_W)) dut (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .video_in(video1),
    .hsync_in(hsync), .vsync_in(vsync), .hblank_in(hblank), .vblank_in(vblank),
    .tint(tint), .invert(invert), .flash_req(flash_req),
    .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hs(hs1), .vga_vs(vs1), .vga_de(de1),
    .flash_busy(busy1), .frame_cnt(fc1), .led(led1));

  vt52_video_colorizer #(.IN_W(3), .FLASH_FRAMES(FF_N), .LED_CNT_W(LED_W)) dut3 (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .video_in(video3),
    .hsync_in(hsync), .vsync_in(vsync), .hblank_in(hblank), .vblank_in(vblank),
    .tint(tint), .invert(invert), .flash_req(flash_req),
    .vga_r(r3), .vga_g(g3), .vga_b(b3), .vga_hs(hs3), .vga_vs(vs3), .vga_de(de3),
    .flash_busy(busy3), .frame_cnt(fc3), .led(led3));

  // clock / reset
  always #5 clk = ~clk;

  logic [LED_W-1:0] tb_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_cnt <= '0;
    else          tb_cnt <= tb_cnt + 1'b1;
  end

  // scoreboard: {rgb1, rgb3, de, hs, vs}
  logic [50:0] exp_q[$];
  logic [50:0] last_exp;
  int checks = 0;
  int fails  = 0;

  logic [2:0] m_tint;
  logic       m_inv, m_pend, m_vs_prev;
  logic [7:0] m_cnt, m_frame;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] cmap(input logic [7:0] l, input logic [2:0] t);
    logic [7:0] ag;
    ag = l - (l >> 2);
    case (t)
      3'd1:    return {l, 8'h00, 8'h00};
      3'd2:    return {8'h00, l, 8'h00};
      3'd3:    return {8'h00, 8'h00, l};
      3'd4:    return {l, ag, 8'h00};
      default: return {l, l, l};
    endcase
  endfunction

  function automatic logic led_fn(input logic [LED_W-1:0] c);
    logic [7:0] d, p;
    d = c[LED_W-2 -: 8];
    p = c[7:0];
    return c[LED_W-1] ? (d > p) : (d <= p);
  endfunction

  task automatic model_reset();
    m_tint = 3'd0; m_inv = 1'b0; m_pend = 1'b0; m_cnt = 8'd0;
    m_frame = 8'd0; m_vs_prev = 1'b0;
    exp_q.delete();
  endtask

  task automatic cmp_video(input logic [50:0] e);
    check("r1", 32'(r1), 32'(e[50:43]));
    check("g1", 32'(g1), 32'(e[42:35]));
    check("b1", 32'(b1), 32'(e[34:27]));
    check("r3", 32'(r3), 32'(e[26:19]));
    check("g3", 32'(g3), 32'(e[18:11]));
    check("b3", 32'(b3), 32'(e[10:3]));
    check("de1", 32'(de1), 32'(e[2]));
    check("de3", 32'(de3), 32'(e[2]));
    check("hs", 32'(hs1), 32'(e[1]));
    check("vs", 32'(vs3), 32'(e[0]));
  endtask

  // driver: one ce_pix cycle, entered and left on a negedge
  task automatic step(input logic v1, input logic [2:0] v3, input logic hs, input logic vs,
                      input logic hb, input logic vb, input logic fr);
    logic [7:0]  l1, l3;
    logic        inv, de, rise, busy_b;
    logic [23:0] c1, c3;
    logic [50:0] e;
    ce_pix = 1'b1; video1 = v1; video3 = v3; hsync = hs; vsync = vs;
    hblank = hb; vblank = vb; flash_req = fr;
    inv = m_inv ^ (m_cnt != 8'd0);
    l1 = {8{v1}};
    l3 = {v3, v3, v3[2:1]};
    if (inv) begin l1 = ~l1; l3 = ~l3; end
    de = ~(hb | vb);
    c1 = de ? cmap(l1, m_tint) : 24'd0;
    c3 = de ? cmap(l3, m_tint) : 24'd0;
    exp_q.push_back({c1, c3, de, hs, vs});
    busy_b = m_pend | (m_cnt != 8'd0);
    rise = vs & ~m_vs_prev;
    m_vs_prev = vs;
    if (rise) begin
      m_frame = m_frame + 8'd1;
      m_tint = tint;
      m_inv = invert;
    end
    if (rise && (m_pend || fr)) begin
      m_cnt = 8'(FF_N); m_pend = 1'b0;
    end else begin
      if (rise && m_cnt != 8'd0) m_cnt = m_cnt - 8'd1;
      if (fr) m_pend = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      last_exp = e;
      cmp_video(e);
    end
    check("flash_busy", 32'(busy1), 32'(m_pend | (m_cnt != 8'd0)));
    check("frame_cnt", 32'(fc3), 32'(m_frame));
    check("led", 32'(led1), 32'(busy_b | led_fn(tb_cnt - 1'b1)));
  endtask

  task automatic vs_pulse();
    step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic pixels(input int n, input logic v1, input logic [2:0] v3);
    for (int i = 0; i < n; i++) step(v1, v3, 1'(i), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; ce_pix = 1'b1; video1 = '0; video3 = '0; hsync = 0; vsync = 0;
    hblank = 0; vblank = 0; tint = 3'd0; invert = 0; flash_req = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_r", 32'(r1), 0);
    check("rst_g", 32'(g3), 0);
    check("rst_de", 32'(de1), 0);
    check("rst_busy", 32'(busy1), 0);
    check("rst_frame", 32'(fc1), 0);
    check("rst_led", 32'(led1), 0);
    reset_n = 1'b1;

    // white, full level
    pixels(8, 1'b1, 3'b101);
    check("white_r1", 32'(r1), 32'hFF);
    check("white_r3", 32'(r3), 32'hB6);

    // amber via one vsync pulse
    tint = 3'd4;
    vs_pulse();
    pixels(5, 1'b1, 3'b101);
    check("amber_r3", 32'(r3), 32'hB6);
    check("amber_g3", 32'(g3), 32'h89);
    check("amber_g1", 32'(g1), 32'hC0);
    check("amber_b3", 32'(b3), 32'h00);

    // mid-frame tint change is deferred to the next frame
    tint = 3'd2;
    pixels(4, 1'b1, 3'b101);
    check("defer_g1", 32'(g1), 32'hC0);
    vs_pulse();
    pixels(4, 1'b1, 3'b111);
    check("green_g1", 32'(g1), 32'hFF);
    check("green_r1", 32'(r1), 32'h00);

    // blanking
    tint = 3'd0;
    vs_pulse();
    for (int i = 0; i < 6; i++) step(1'b1, 3'd5, 1'b0, 1'b0, 1'(i < 3), 1'b0, 1'b0);
    pixels(2, 1'b1, 3'd5);

    // invert and randomised traffic
    invert = 1'b1;
    vs_pulse();
    pixels(4, 1'b1, 3'd5);
    pixels(4, 1'b0, 3'd2);
    for (int f = 0; f < 4; f++) begin
      tint = 3'($urandom_range(0, 7));
      invert = 1'($urandom_range(0, 1));
      vs_pulse();
      for (int i = 0; i < 12; i++)
        step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             1'b0, 1'($urandom_range(0, 3) == 0), 1'b0, 1'b0);
    end
    tint = 3'd0; invert = 1'b0;
    vs_pulse();

    // visual bell, with a restart in frame 2
    pixels(3, 1'b1, 3'd5);
    step(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bell_busy", 32'(busy3), 1);
    pixels(2, 1'b1, 3'd5);
    for (int f = 1; f <= 8; f++) begin
      vs_pulse();
      pixels(3, 1'b1, 3'd5);
      if (f == 2) step(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      pixels(2, 1'b0, 3'd2);
    end
    check("bell_done", 32'(busy1), 0);
    // coincident request and vsync rising edge
    step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    pixels(3, 1'b1, 3'd5);
    check("bell_coinc_r1", 32'(r1), 32'h00);

    // ce_pix hold: outputs frozen
    pixels(3, 1'b1, 3'd3);
    ce_pix = 1'b0;
    for (int i = 0; i < 10; i++) begin
      video1 = 1'($urandom_range(0, 1)); video3 = 3'($urandom_range(0, 7));
      hsync = 1'($urandom_range(0, 1)); vsync = 1'($urandom_range(0, 1));
      hblank = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      cmp_video(last_exp);
      check("hold_frame", 32'(fc1), 32'(m_frame));
    end
    pixels(4, 1'b1, 3'd6);

    // frame counter wrap
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("wrap_frame", 32'(fc1), 32'(m_frame));

    // asynchronous reset mid-line
    tint = 3'd1; invert = 1'b1;
    vs_pulse();
    pixels(4, 1'b1, 3'd5);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_r1", 32'(r1), 0);
    check("arst_r3", 32'(r3), 0);
    check("arst_de", 32'(de3), 0);
    check("arst_frame", 32'(fc1), 0);
    check("arst_led", 32'(led1), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    pixels(5, 1'b1, 3'd5);
    check("post_rst_g1", 32'(g1), 32'hFF);
    check("post_rst_b3", 32'(b3), 32'hB6);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
